// File: rtl/i2s_pkg.sv
// Shared types and widths for the I2S DSP-mode frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

  localparam int BIT_W   = 5;
  localparam int WORD_W  = 4;
  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // RUN and STOP both clock bits out; only IDLE/ARM are quiet.
  function automatic logic is_busy(state_e s);
    return (s == ST_RUN) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/i2s_wrap_counter.sv
// Modulo counter 0..max with a wrap strobe, used for both bit and word indices.
// Latency: cnt updates one cycle after en; wrap is combinational from cnt/max/en.
// Backpressure: none; clr dominates en.
module i2s_wrap_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  assign wrap = en && (cnt == max);

  // Count up while enabled, return to zero after reaching max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_dsp_frame_ctrl.sv
// Frame/word/bit sequencer for a DSP-mode I2S transmit channel, with underrun flag.
// Latency: all outputs registered; ws/word_start/counters describe the current bit cycle, err_o lags underrun by one.
// Backpressure: none; FIFO handshake is only monitored, frames never stall and are never truncated.
module i2s_tx_dsp_frame_ctrl
  import i2s_pkg::*;
(
  input  logic               sck_i,
  input  logic               rst_i,
  input  logic               cfg_en_i,
  input  logic [BIT_W-1:0]   cfg_num_bits_i,
  input  logic [WORD_W-1:0]  cfg_num_word_i,
  input  logic               cfg_err_clr_i,
  input  logic               ready_to_send_i,
  input  logic               fifo_data_valid_i,
  input  logic               fifo_data_ready_i,
  output logic               ws_o,
  output logic               word_start_o,
  output logic [BIT_W-1:0]   bit_cnt_o,
  output logic [WORD_W-1:0]  word_cnt_o,
  output logic               busy_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic               err_o
);

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    nb_q;
  logic [WORD_W-1:0]   nw_q;
  logic                run_busy;
  logic                busy_d;
  logic                start;
  logic                bit_wrap;
  logic                frame_end;

  assign run_busy = is_busy(state_q);
  assign busy_d   = is_busy(state_d);
  assign start    = (state_q == ST_ARM) && cfg_en_i && ready_to_send_i;

  i2s_wrap_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk  (sck_i),
    .rst  (rst_i),
    .clr  (!run_busy),
    .en   (run_busy),
    .max  (nb_q),
    .cnt  (bit_cnt_o),
    .wrap (bit_wrap)
  );

  i2s_wrap_counter #(.WIDTH(WORD_W)) u_word_cnt (
    .clk  (sck_i),
    .rst  (rst_i),
    .clr  (!run_busy),
    .en   (bit_wrap),
    .max  (nw_q),
    .cnt  (word_cnt_o),
    .wrap (frame_end)
  );

  // State register.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: STOP drains the current frame; a frame end in STOP always ends in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_en_i) state_d = ST_ARM;
      ST_ARM: begin
        if (!cfg_en_i)            state_d = ST_IDLE;
        else if (ready_to_send_i) state_d = ST_RUN;
      end
      ST_RUN:  if (!cfg_en_i) state_d = ST_STOP;
      ST_STOP: begin
        if (frame_end)     state_d = ST_IDLE;
        else if (cfg_en_i) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame geometry is sampled only at frame boundaries so a running frame keeps its shape.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      nb_q <= '0;
      nw_q <= '0;
    end else if (start || frame_end) begin
      nb_q <= cfg_num_bits_i;
      nw_q <= cfg_num_word_i;
    end
  end

  // Strobes are precomputed from next-cycle position so they stay flop outputs.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      ws_o         <= 1'b0;
      word_start_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      ws_o         <= (state_d == ST_RUN) && (start || frame_end);
      word_start_o <= busy_d && (start || bit_wrap);
      busy_o       <= busy_d;
    end
  end

  // Completed-frame counter, free-running modulo 2^16.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i)          frame_cnt_o <= '0;
    else if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
  end

  // Sticky underrun flag; a new underrun wins over a simultaneous clear.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i)                                                  err_o <= 1'b0;
    else if (busy_o && fifo_data_ready_i && !fifo_data_valid_i) err_o <= 1'b1;
    else if (cfg_err_clr_i)                                     err_o <= 1'b0;
  end

endmodule

// File: tb/tb_i2s_tx_dsp_frame_ctrl.sv
// Bench for the I2S DSP-mode frame controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2s_tx_dsp_frame_ctrl;

  logic        sck_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic [4:0]  cfg_num_bits_i = 5'd0;
  logic [3:0]  cfg_num_word_i = 4'd0;
  logic        cfg_err_clr_i = 1'b0;
  logic        ready_to_send_i = 1'b0;
  logic        fifo_data_valid_i = 1'b1;
  logic        fifo_data_ready_i = 1'b0;
  logic        ws_o, word_start_o, busy_o, err_o;
  logic [4:0]  bit_cnt_o;
  logic [3:0]  word_cnt_o;
  logic [15:0] frame_cnt_o;
  logic [28:0] act_vec;

  int checks = 0;
  int errors = 0;

  i2s_tx_dsp_frame_ctrl dut (
    .sck_i             (sck_i),
    .rst_i             (rst_i),
    .cfg_en_i          (cfg_en_i),
    .cfg_num_bits_i    (cfg_num_bits_i),
    .cfg_num_word_i    (cfg_num_word_i),
    .cfg_err_clr_i     (cfg_err_clr_i),
    .ready_to_send_i   (ready_to_send_i),
    .fifo_data_valid_i (fifo_data_valid_i),
    .fifo_data_ready_i (fifo_data_ready_i),
    .ws_o              (ws_o),
    .word_start_o      (word_start_o),
    .bit_cnt_o         (bit_cnt_o),
    .word_cnt_o        (word_cnt_o),
    .busy_o            (busy_o),
    .frame_cnt_o       (frame_cnt_o),
    .err_o             (err_o)
  );

  always #5 sck_i = ~sck_i;

  assign act_vec = {ws_o, word_start_o, busy_o, err_o, bit_cnt_o, word_cnt_o, frame_cnt_o};

  // Reference model: position within a frame of length (nb+1)*(nw+1).
  bit          m_armed, m_active, m_drain, m_err;
  int          m_pos, m_nb, m_len;
  logic [15:0] m_frames;

  function automatic void model_reset();
    m_armed = 0; m_active = 0; m_drain = 0; m_err = 0;
    m_pos = 0; m_nb = 0; m_len = 1; m_frames = 16'd0;
  endfunction

  function automatic void model_latch();
    m_nb  = int'(cfg_num_bits_i);
    m_len = (m_nb + 1) * (int'(cfg_num_word_i) + 1);
  endfunction

  function automatic void model_step();
    bit und;
    und = m_active && fifo_data_ready_i && !fifo_data_valid_i;
    if (und) m_err = 1;
    else if (cfg_err_clr_i) m_err = 0;
    if (!m_active) begin
      if (!m_armed) m_armed = cfg_en_i;
      else if (!cfg_en_i) m_armed = 0;
      else if (ready_to_send_i) begin
        m_armed = 0; m_active = 1; m_drain = 0; m_pos = 0;
        model_latch();
      end
    end else if (m_pos == m_len - 1) begin
      m_frames = m_frames + 16'd1;
      m_pos = 0;
      if (m_drain) m_active = 0;
      else m_drain = !cfg_en_i;
      model_latch();
    end else begin
      m_pos++;
      m_drain = !cfg_en_i;
    end
  endfunction

  function automatic logic [28:0] exp_vec();
    logic [4:0] b;
    logic [3:0] w;
    logic       ws, wst;
    b   = m_active ? 5'(m_pos % (m_nb + 1)) : 5'd0;
    w   = m_active ? 4'(m_pos / (m_nb + 1)) : 4'd0;
    ws  = m_active && !m_drain && (m_pos == 0);
    wst = m_active && (b == 5'd0);
    return {ws, wst, m_active, m_err, b, w, m_frames};
  endfunction

  task automatic tick();
    model_step();
    @(posedge sck_i);
    #1;
  endtask

  task automatic do_reset();
    cfg_en_i = 0; ready_to_send_i = 0; cfg_err_clr_i = 0;
    fifo_data_valid_i = 1; fifo_data_ready_i = 0;
    rst_i = 1;
    model_reset();
    @(posedge sck_i); #1;
    @(posedge sck_i); #1;
    rst_i = 0;
  endtask

  task automatic test_reset();
    #2 rst_i = 1;
    model_reset();
    #1;
    checks++;
    if (act_vec !== 29'd0) begin
      errors++; $display("FAIL reset_state got %h exp %h", act_vec, 29'd0);
    end
    @(posedge sck_i); #1;
    rst_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_idle got %h exp %h", act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ws_period();
    do_reset();
    cfg_num_bits_i = 5'd15; cfg_num_word_i = 4'd1; cfg_en_i = 1;
    tick();
    tick(); tick();
    ready_to_send_i = 1;
    tick();
    for (int i = 0; i < 96; i++) begin
      checks++;
      if (ws_o !== (i % 32 == 0)) begin
        errors++; $display("FAIL ws_period i=%0d got %b exp %b", i, ws_o, (i % 32 == 0));
      end
      checks++;
      if (word_start_o !== (i % 16 == 0)) begin
        errors++; $display("FAIL word_start_period i=%0d got %b exp %b", i, word_start_o, (i % 16 == 0));
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL ws_period_model i=%0d got %h exp %h", i, act_vec, exp_vec());
      end
      fifo_data_valid_i = 1'($urandom);
      fifo_data_ready_i = 1'($urandom);
      tick();
    end
  endtask

  task automatic test_stop_drain();
    do_reset();
    cfg_num_bits_i = 5'd7; cfg_num_word_i = 4'd3; cfg_en_i = 1; ready_to_send_i = 1;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bit_cnt_o !== 5'd5 || word_cnt_o !== 4'd0) begin
      errors++; $display("FAIL stop_pos got %0d/%0d exp 5/0", bit_cnt_o, word_cnt_o);
    end
    cfg_en_i = 0;
    for (int k = 0; k < 27; k++) begin
      checks++;
      if (busy_o !== 1'b1 || ws_o !== 1'b0) begin
        errors++; $display("FAIL stop_drain k=%0d got busy=%b ws=%b exp busy=1 ws=0", k, busy_o, ws_o);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL stop_model k=%0d got %h exp %h", k, act_vec, exp_vec());
      end
      tick();
    end
    checks++;
    if (busy_o !== 1'b0 || frame_cnt_o !== 16'd1 || bit_cnt_o !== 5'd0) begin
      errors++; $display("FAIL stop_idle got busy=%b frames=%0d exp busy=0 frames=1", busy_o, frame_cnt_o);
    end
  endtask

  task automatic test_cfg_change();
    do_reset();
    cfg_num_bits_i = 5'd15; cfg_num_word_i = 4'd1; cfg_en_i = 1; ready_to_send_i = 1;
    tick(); tick();
    for (int i = 0; i <= 64; i++) begin
      if (i == 10) cfg_num_bits_i = 5'd7;
      checks++;
      if (ws_o !== (i == 0 || i == 32 || i == 48 || i == 64)) begin
        errors++; $display("FAIL cfg_change i=%0d got ws=%b", i, ws_o);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL cfg_change_model i=%0d got %h exp %h", i, act_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_underrun();
    logic [2:0] stim [5];
    logic       want [5];
    stim = '{3'b100, 3'b010, 3'b101, 3'b011, 3'b010};
    want = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    cfg_num_bits_i = 5'd15; cfg_num_word_i = 4'd1; cfg_en_i = 1; ready_to_send_i = 1;
    tick(); tick();
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL underrun_pre got err=%b busy=%b exp 0/1", err_o, busy_o);
    end
    for (int i = 0; i < 5; i++) begin
      fifo_data_ready_i = stim[i][2];
      fifo_data_valid_i = stim[i][1];
      cfg_err_clr_i     = stim[i][0];
      tick();
      checks++;
      if (err_o !== want[i]) begin
        errors++; $display("FAIL underrun step=%0d got %b exp %b", i, err_o, want[i]);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL underrun_model step=%0d got %h exp %h", i, act_vec, exp_vec());
      end
    end
    cfg_err_clr_i = 0;
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    cfg_num_bits_i = 5'd0; cfg_num_word_i = 4'd0; cfg_en_i = 1; ready_to_send_i = 1;
    tick(); tick();
    n = 0;
    while (frame_cnt_o !== 16'hFFFE && n < 70000) begin
      checks++;
      if (ws_o !== 1'b1 || frame_cnt_o !== m_frames) begin
        errors++; $display("FAIL b2b n=%0d got ws=%b frames=%h exp 1/%h", n, ws_o, frame_cnt_o, m_frames);
      end
      tick();
      n++;
    end
    checks++;
    if (frame_cnt_o !== 16'hFFFE) begin
      errors++; $display("FAIL b2b_timeout got %h exp fffe", frame_cnt_o);
    end
    tick();
    checks++;
    if (frame_cnt_o !== 16'hFFFF || ws_o !== 1'b1) begin
      errors++; $display("FAIL b2b_ffff got %h ws=%b exp ffff ws=1", frame_cnt_o, ws_o);
    end
    tick();
    checks++;
    if (frame_cnt_o !== 16'h0000 || ws_o !== 1'b1) begin
      errors++; $display("FAIL b2b_wrap got %h ws=%b exp 0000 ws=1", frame_cnt_o, ws_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_num_bits_i = 5'd7; cfg_num_word_i = 4'd3; cfg_en_i = 1; ready_to_send_i = 1;
    fifo_data_ready_i = 1; fifo_data_valid_i = 0;
    tick(); tick();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (busy_o !== 1'b1 || err_o !== 1'b1 || act_vec !== exp_vec()) begin
      errors++; $display("FAIL areset_pre got %h exp %h", act_vec, exp_vec());
    end
    fifo_data_ready_i = 0; fifo_data_valid_i = 1;
    #2 rst_i = 1;
    model_reset();
    #1;
    checks++;
    if (act_vec !== 29'd0) begin
      errors++; $display("FAIL areset_async got %h exp 0", act_vec);
    end
    @(posedge sck_i); #1;
    rst_i = 0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || act_vec !== exp_vec()) begin
      errors++; $display("FAIL areset_arm got %h exp %h", act_vec, exp_vec());
    end
    tick();
    checks++;
    if (busy_o !== 1'b1 || ws_o !== 1'b1 || act_vec !== exp_vec()) begin
      errors++; $display("FAIL areset_run got %h exp %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cfg_en_i          = ($urandom_range(0, 15) != 0);
      ready_to_send_i   = ($urandom_range(0, 3) == 0);
      fifo_data_valid_i = 1'($urandom);
      fifo_data_ready_i = 1'($urandom);
      cfg_err_clr_i     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_num_bits_i = 5'($urandom_range(0, 7));
        cfg_num_word_i = 4'($urandom_range(0, 3));
      end
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d got %h exp %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ws_period();
    test_stop_drain();
    test_cfg_change();
    test_underrun();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_dsp_frame_ctrl.md
I2S_TX_DSP_FRAME_CTRL -- requirements
Module: i2s_tx_dsp_frame_ctrl

Interface
REQ-001 SHALL have port: sck_i  in  1  sole clock; all flops on posedge.
REQ-002 SHALL have port: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: cfg_en_i  in  1  frame generation enable.
REQ-004 SHALL have port: cfg_num_bits_i  in  5  bits per word minus 1 (nb).
REQ-005 SHALL have port: cfg_num_word_i  in  4  words per frame minus 1 (nw).
REQ-006 SHALL have port: cfg_err_clr_i  in  1  one-cycle pulse, clears err_o.
REQ-007 SHALL have port: ready_to_send_i  in  1  channel has preloaded both shift registers.
REQ-008 SHALL have port: fifo_data_valid_i  in  1  FIFO valid, monitored only.
REQ-009 SHALL have port: fifo_data_ready_i  in  1  channel pop request, monitored only.
REQ-010 SHALL have port: ws_o  out  1  frame-sync pulse, high in the first bit cycle of each frame.
REQ-011 SHALL have port: word_start_o  out  1  high in the first bit cycle of each word.
REQ-012 SHALL have port: bit_cnt_o  out  5  current bit index within the word.
REQ-013 SHALL have port: word_cnt_o  out  4  current word index within the frame.
REQ-014 SHALL have port: busy_o  out  1  high in RUN and STOP.
REQ-015 SHALL have port: frame_cnt_o  out  16  completed-frame count.
REQ-016 SHALL have port: err_o  out  1  sticky FIFO-underrun flag.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, RUN, STOP.
REQ-018 IDLE: cfg_en_i=1 SHALL move to ARM on the next cycle; otherwise stay.
REQ-019 ARM: cfg_en_i=0 SHALL return to IDLE; else ready_to_send_i=1 SHALL enter RUN with bit_cnt=0, word_cnt=0, and latch nb/nw into shadow registers.
REQ-020 RUN/STOP: each cycle bit_cnt SHALL increment; when bit_cnt==shadow nb it SHALL wrap to 0 and word_cnt SHALL increment.
REQ-021 Frame end (bit_cnt==nb and word_cnt==nw) SHALL wrap word_cnt to 0, increment frame_cnt (0xFFFF wraps to 0) and re-latch nb/nw from the cfg inputs.
REQ-022 Config changes mid-frame SHALL NOT affect the current frame.
REQ-023 RUN with cfg_en_i=0 SHALL go to STOP, counting continues; the current frame is never truncated.
REQ-024 STOP with cfg_en_i=1 SHALL return to RUN with no counter disturbance.
REQ-025 At frame end: state RUN SHALL stay in RUN (new frame next cycle); state STOP SHALL go to IDLE.
REQ-026 ws_o SHALL be 1 exactly in cycles where state==RUN, bit_cnt==0 and word_cnt==0; it is never asserted in STOP.
REQ-027 word_start_o SHALL be 1 in every RUN/STOP cycle with bit_cnt==0.
REQ-028 Outside RUN/STOP: bit_cnt_o, word_cnt_o, ws_o, word_start_o and busy_o SHALL be 0.
REQ-029 nb=0 with nw=0 SHALL produce ws_o=1 on every RUN cycle, with frame_cnt incrementing each cycle.
REQ-030 Underrun, defined as busy_o=1 and fifo_data_ready_i=1 and fifo_data_valid_i=0, SHALL set err_o on the next cycle.
REQ-031 err_o SHALL clear on cfg_err_clr_i; a simultaneous underrun and clear SHALL leave err_o=1.
REQ-032 Every output SHALL be registered.

Reset
REQ-033 rst_i=1 SHALL immediately force IDLE with all outputs, counters and shadow registers at 0, including err_o and frame_cnt_o.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release the block re-enters via ARM.

Structure
REQ-035 Package i2s_pkg SHALL hold the state enum typedef and the width constants (5/4/16).
REQ-036 Bit and word counting SHALL use one sub-module, i2s_wrap_counter (parameter width; inputs en and max; outputs cnt and wrap), instantiated twice.

Verification
REQ-037 Test nb=15, nw=1, ready after 3 cycles, en held: ws_o pulses every 32 cycles, starting the first RUN cycle; word_start_o every 16 cycles.
REQ-038 Test en dropped at bit 5 of word 0, nb=7, nw=3: busy_o stays 1 for the remaining 27 cycles, no further ws_o, then IDLE and frame_cnt_o +1.
REQ-039 Test nb changed 15->7 mid-frame: the current frame stays 32 cycles (nw=1); the next frame is 16 cycles.
REQ-040 Test ready=1, valid=0 in RUN: err_o=1 the next cycle; a clear in the same cycle as a second underrun leaves err_o=1; a lone clear drops it.
REQ-041 Test nb=0, nw=0: ws_o constant 1 in RUN and frame_cnt_o counts every cycle; preset at 0xFFFE it reads 0xFFFF then 0x0000.
REQ-042 Test rst_i pulse mid-frame: all outputs 0 asynchronously; after release, IDLE->ARM->RUN when en=1 and ready=1.
